// File: rtl/pio_irq_service_master_pkg.sv
// Shared types and PIO register map for the PIO irq service master.
package pio_irq_service_master_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD_WR,
        S_RD_DATA,
        S_WAIT_DATA,
        S_RD_EDGE,
        S_WAIT_EDGE,
        S_CLR_EDGE,
        S_EVT_OUT
    } state_e;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_SET   = 2'b01,
        OP_CLEAR = 2'b10,
        OP_MASK  = 2'b11
    } cmd_op_e;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_MASK   = 3'd2;
    localparam logic [2:0] ADDR_EDGE   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    function automatic logic [2:0] op_addr(input logic [1:0] op);
        logic [2:0] a;
        case (op)
            OP_WRITE: a = ADDR_DATA;
            OP_SET:   a = ADDR_OUTSET;
            OP_CLEAR: a = ADDR_OUTCLR;
            default:  a = ADDR_MASK;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/pio_irq_service_master_port.sv
// Avalon-MM request holder: keeps a transfer asserted until accepted and
// times the fixed read latency so the FSM knows when m_readdata is valid.
module pio_bus_master_port
    import pio_irq_service_master_pkg::*;
#(
    parameter int DATA_W       = 1,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_start,
    input  logic              req_write,
    input  logic [2:0]        req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              req_accepted,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [2:0]        m_address,
    output logic              m_chipselect,
    output logic              m_write_n,
    output logic [31:0]       m_writedata,
    input  logic [31:0]       m_readdata,
    input  logic              m_waitrequest
);

    localparam logic [2:0] LAT = 3'(READ_LATENCY);

    logic        cs_q, cs_d;
    logic        wn_q, wn_d;
    logic [2:0]  addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    logic [2:0]  lat_q, lat_d;
    logic        unused_rdata;

    assign req_accepted = cs_q & ~m_waitrequest;
    assign rd_valid     = (lat_q == 3'd1);
    assign rd_data      = m_readdata[DATA_W-1:0];
    assign unused_rdata = ^m_readdata;

    always_comb begin
        cs_d   = cs_q;
        wn_d   = wn_q;
        addr_d = addr_q;
        wd_d   = wd_q;
        lat_d  = lat_q;
        if (req_accepted) begin
            cs_d = 1'b0;
            if (wn_q) lat_d = LAT;
        end else if (lat_q != 3'd0) begin
            lat_d = lat_q - 3'd1;
        end
        // a new request is only issued once the previous one has retired
        if (req_start) begin
            cs_d   = 1'b1;
            wn_d   = ~req_write;
            addr_d = req_addr;
            wd_d   = 32'(req_data);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_q   <= 1'b0;
            wn_q   <= 1'b1;
            addr_q <= ADDR_DATA;
            wd_q   <= '0;
            lat_q  <= '0;
        end else begin
            cs_q   <= cs_d;
            wn_q   <= wn_d;
            addr_q <= addr_d;
            wd_q   <= wd_d;
            lat_q  <= lat_d;
        end
    end

    assign m_chipselect = cs_q;
    assign m_write_n    = wn_q;
    assign m_address    = addr_q;
    assign m_writedata  = wd_q;

endmodule

// File: rtl/pio_irq_service_master.sv
// Services the PIO edge-capture interrupt in hardware and executes
// fabric output-port commands over a single Avalon-MM initiator port.
module pio_irq_service_master
    import pio_irq_service_master_pkg::*;
#(
    parameter int DATA_W       = 1,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              irq,
    output logic [2:0]        m_address,
    output logic              m_chipselect,
    output logic              m_write_n,
    output logic [31:0]       m_writedata,
    input  logic [31:0]       m_readdata,
    input  logic              m_waitrequest,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [DATA_W-1:0] evt_data,
    output logic [DATA_W-1:0] evt_edges,
    output logic              spurious,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] edges_q, edges_d;
    logic              evt_valid_q, evt_valid_d;
    logic              spurious_q, spurious_d;

    logic              req_start, req_write;
    logic [2:0]        req_addr;
    logic [DATA_W-1:0] req_data;
    logic              req_accepted, rd_valid;
    logic [DATA_W-1:0] rd_data;

    pio_bus_master_port #(
        .DATA_W      (DATA_W),
        .READ_LATENCY(READ_LATENCY)
    ) u_port (
        .clk          (clk),
        .reset        (reset),
        .req_start    (req_start),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_accepted (req_accepted),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata),
        .m_readdata   (m_readdata),
        .m_waitrequest(m_waitrequest)
    );

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        edges_d     = edges_q;
        evt_valid_d = evt_valid_q;
        spurious_d  = 1'b0;
        req_start   = 1'b0;
        req_write   = 1'b0;
        req_addr    = ADDR_DATA;
        req_data    = '0;
        case (state_q)
            S_IDLE: begin
                if (irq) begin
                    state_d   = S_RD_DATA;
                    req_start = 1'b1;
                end else if (cmd_valid) begin
                    state_d   = S_CMD_WR;
                    req_start = 1'b1;
                    req_write = 1'b1;
                    req_addr  = op_addr(cmd_op);
                    req_data  = cmd_data;
                end
            end
            S_CMD_WR: if (req_accepted) state_d = S_IDLE;
            S_RD_DATA: if (req_accepted) state_d = S_WAIT_DATA;
            S_WAIT_DATA: begin
                if (rd_valid) begin
                    data_d    = rd_data;
                    state_d   = S_RD_EDGE;
                    req_start = 1'b1;
                    req_addr  = ADDR_EDGE;
                end
            end
            S_RD_EDGE: if (req_accepted) state_d = S_WAIT_EDGE;
            S_WAIT_EDGE: begin
                if (rd_valid) begin
                    edges_d = rd_data;
                    if (rd_data == '0) begin
                        spurious_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        state_d   = S_CLR_EDGE;
                        req_start = 1'b1;
                        req_write = 1'b1;
                        req_addr  = ADDR_EDGE;
                        req_data  = rd_data;
                    end
                end
            end
            S_CLR_EDGE: begin
                if (req_accepted) begin
                    state_d     = S_EVT_OUT;
                    evt_valid_d = 1'b1;
                end
            end
            S_EVT_OUT: begin
                if (evt_ready) begin
                    state_d     = S_IDLE;
                    evt_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            data_q      <= '0;
            edges_q     <= '0;
            evt_valid_q <= 1'b0;
            spurious_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            edges_q     <= edges_d;
            evt_valid_q <= evt_valid_d;
            spurious_q  <= spurious_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE) & ~irq;
    assign busy      = (state_q != S_IDLE);
    assign evt_valid = evt_valid_q;
    assign evt_data  = data_q;
    assign evt_edges = edges_q;
    assign spurious  = spurious_q;

endmodule

// File: tb/tb_pio_irq_service_master.sv
// Directed bench: two instances (latency 1 no stalls, latency 2 with
// 3-cycle waitrequest stalls) each talking to a small PIO stub.
module tb_pio_irq_service_master;

    logic clk = 1'b0;
    logic rst, srst;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // instance A: DATA_W=8, READ_LATENCY=1, no stalls
    logic        irq_a, cs_a, wn_a, wreq_a;
    logic [2:0]  addr_a;
    logic [31:0] wd_a, rdd_a;
    logic        cmd_valid_a, cmd_ready_a;
    logic [1:0]  cmd_op_a;
    logic [7:0]  cmd_data_a;
    logic        evt_valid_a, evt_ready_a, spur_a, busy_a;
    logic [7:0]  evt_data_a, evt_edges_a;

    // instance B: DATA_W=8, READ_LATENCY=2, stalled transfers
    logic        irq_b, cs_b, wn_b, wreq_b;
    logic [2:0]  addr_b;
    logic [31:0] wd_b, rdd_b;
    logic        cmd_valid_b, cmd_ready_b;
    logic [1:0]  cmd_op_b;
    logic [7:0]  cmd_data_b;
    logic        evt_valid_b, evt_ready_b, spur_b, busy_b;
    logic [7:0]  evt_data_b, evt_edges_b;

    pio_irq_service_master #(.DATA_W(8), .READ_LATENCY(1)) u_dut_a (
        .clk(clk), .reset(rst), .irq(irq_a),
        .m_address(addr_a), .m_chipselect(cs_a), .m_write_n(wn_a),
        .m_writedata(wd_a), .m_readdata(rdd_a), .m_waitrequest(wreq_a),
        .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
        .cmd_op(cmd_op_a), .cmd_data(cmd_data_a),
        .evt_valid(evt_valid_a), .evt_ready(evt_ready_a),
        .evt_data(evt_data_a), .evt_edges(evt_edges_a),
        .spurious(spur_a), .busy(busy_a)
    );

    pio_irq_service_master #(.DATA_W(8), .READ_LATENCY(2)) u_dut_b (
        .clk(clk), .reset(rst), .irq(irq_b),
        .m_address(addr_b), .m_chipselect(cs_b), .m_write_n(wn_b),
        .m_writedata(wd_b), .m_readdata(rdd_b), .m_waitrequest(wreq_b),
        .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
        .cmd_op(cmd_op_b), .cmd_data(cmd_data_b),
        .evt_valid(evt_valid_b), .evt_ready(evt_ready_b),
        .evt_data(evt_data_b), .evt_edges(evt_edges_b),
        .spurious(spur_b), .busy(busy_b)
    );

    // PIO stub A
    logic [7:0] pin_a, set_a, edge_a, out_a, mask_a, rd_a;
    logic       force_a;
    assign irq_a = (|edge_a) | force_a;
    assign rdd_a = {24'h0, rd_a};

    always @(posedge clk or posedge srst) begin
        if (srst) begin
            edge_a <= 8'h00; out_a <= 8'h00; mask_a <= 8'h00; rd_a <= 8'h00;
        end else begin
            rd_a   <= 8'h00;
            edge_a <= edge_a | set_a;
            if (cs_a && !wreq_a) begin
                if (wn_a) begin
                    case (addr_a)
                        3'd0:    rd_a <= pin_a;
                        3'd2:    rd_a <= mask_a;
                        3'd3:    rd_a <= edge_a;
                        default: rd_a <= out_a;
                    endcase
                end else begin
                    case (addr_a)
                        3'd0:    out_a  <= wd_a[7:0];
                        3'd4:    out_a  <= out_a | wd_a[7:0];
                        3'd5:    out_a  <= out_a & ~wd_a[7:0];
                        3'd2:    mask_a <= wd_a[7:0];
                        3'd3:    edge_a <= (edge_a | set_a) & ~wd_a[7:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // PIO stub B: 3 stall cycles per transfer, two-cycle read pipeline
    logic [7:0] pin_b, set_b, edge_b, rd1_b, rd2_b;
    logic [1:0] scnt_b;
    assign irq_b  = |edge_b;
    assign wreq_b = cs_b && (scnt_b < 2'd3);
    assign rdd_b  = {24'h0, rd2_b};

    always @(posedge clk or posedge srst) begin
        if (srst) begin
            edge_b <= 8'h00; rd1_b <= 8'h00; rd2_b <= 8'h00; scnt_b <= 2'd0;
        end else begin
            scnt_b <= (cs_b && wreq_b) ? 2'(scnt_b + 2'd1) : 2'd0;
            rd1_b  <= 8'h00;
            rd2_b  <= rd1_b;
            edge_b <= edge_b | set_b;
            if (cs_b && !wreq_b) begin
                if (wn_b) rd1_b <= (addr_b == 3'd0) ? pin_b :
                                   (addr_b == 3'd3) ? edge_b : 8'h00;
                else if (addr_b == 3'd3)
                    edge_b <= (edge_b | set_b) & ~wd_b[7:0];
            end
        end
    end

    // accepted-transfer log
    logic [2:0] la [64];
    logic       lw [64];
    logic [7:0] ld [64];
    int na = 0;
    int nb = 0;
    always @(negedge clk) begin
        if (cs_a && !wreq_a) begin
            la[na % 64] = addr_a; lw[na % 64] = wn_a; ld[na % 64] = wd_a[7:0];
            na++;
        end
        if (cs_b && !wreq_b) nb++;
    end

    task automatic test_reset();
        rst = 1'b1; srst = 1'b1;
        force_a = 0; set_a = 0; pin_a = 0; wreq_a = 0;
        cmd_valid_a = 0; cmd_op_a = 0; cmd_data_a = 0; evt_ready_a = 1;
        set_b = 0; pin_b = 0; cmd_valid_b = 0; cmd_op_b = 0; cmd_data_b = 0;
        evt_ready_b = 1;
        repeat (2) @(negedge clk);
        srst = 1'b0;
        @(negedge clk);
        n_cmp++; if (cs_a !== 1'b0) begin n_bad++; $display("FAIL rst_cs got %b want 0", cs_a); end
        n_cmp++; if (wn_a !== 1'b1) begin n_bad++; $display("FAIL rst_write_n got %b want 1", wn_a); end
        n_cmp++; if (addr_a !== 3'd0) begin n_bad++; $display("FAIL rst_addr got %0d want 0", addr_a); end
        n_cmp++; if (wd_a !== 32'h0) begin n_bad++; $display("FAIL rst_wdata got %h want 0", wd_a); end
        n_cmp++; if (evt_valid_a !== 1'b0) begin n_bad++; $display("FAIL rst_evt_valid got %b want 0", evt_valid_a); end
        n_cmp++; if (evt_data_a !== 8'h00) begin n_bad++; $display("FAIL rst_evt_data got %h want 0", evt_data_a); end
        n_cmp++; if (evt_edges_a !== 8'h00) begin n_bad++; $display("FAIL rst_evt_edges got %h want 0", evt_edges_a); end
        n_cmp++; if (spur_a !== 1'b0) begin n_bad++; $display("FAIL rst_spurious got %b want 0", spur_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy_a); end
        n_cmp++; if (cmd_ready_a !== 1'b1) begin n_bad++; $display("FAIL rst_cmd_ready_noirq got %b want 1", cmd_ready_a); end
        force_a = 1'b1; #1;
        n_cmp++; if (cmd_ready_a !== 1'b0) begin n_bad++; $display("FAIL rst_cmd_ready_irq got %b want 0", cmd_ready_a); end
        force_a = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_irq_service();
        int ev = -1;
        int base = na;
        logic irq6 = 1'b1;
        logic [7:0] d = 8'h00, e = 8'h00;
        pin_a = 8'h01; set_a = 8'h01;
        @(negedge clk);
        set_a = 8'h00;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1 && {cs_a, wn_a, addr_a} !== {1'b1, 1'b1, 3'd0}) begin
                n_bad++; $display("FAIL irq_c1_read got cs%b wn%b a%0d want cs1 wn1 a0", cs_a, wn_a, addr_a);
            end
            if (i == 3 && {cs_a, wn_a, addr_a} !== {1'b1, 1'b1, 3'd3}) begin
                n_bad++; $display("FAIL irq_c3_read got cs%b wn%b a%0d want cs1 wn1 a3", cs_a, wn_a, addr_a);
            end
            if (i == 5 && {cs_a, wn_a, addr_a, wd_a} !== {1'b1, 1'b0, 3'd3, 32'h1}) begin
                n_bad++; $display("FAIL irq_c5_clear got cs%b wn%b a%0d d%h want cs1 wn0 a3 d1", cs_a, wn_a, addr_a, wd_a);
            end
            if (i == 1 || i == 3 || i == 5) n_cmp++;
            if (evt_valid_a && ev < 0) begin
                ev = i; irq6 = irq_a; d = evt_data_a; e = evt_edges_a;
            end
        end
        n_cmp++; if (ev != 6) begin n_bad++; $display("FAIL irq_evt_cycle got %0d want 6", ev); end
        n_cmp++; if (d !== 8'h01) begin n_bad++; $display("FAIL irq_evt_data got %h want 01", d); end
        n_cmp++; if (e !== 8'h01) begin n_bad++; $display("FAIL irq_evt_edges got %h want 01", e); end
        n_cmp++; if (irq6 !== 1'b0) begin n_bad++; $display("FAIL irq_low_after_clear got %b want 0", irq6); end
        n_cmp++; if (na - base != 3) begin n_bad++; $display("FAIL irq_xfer_count got %0d want 3", na - base); end
        n_cmp++;
        if ({la[base % 64], lw[base % 64], la[(base + 1) % 64], lw[(base + 1) % 64],
             la[(base + 2) % 64], lw[(base + 2) % 64], ld[(base + 2) % 64]}
            !== {3'd0, 1'b1, 3'd3, 1'b1, 3'd3, 1'b0, 8'h01}) begin
            n_bad++; $display("FAIL irq_xfer_seq got a%0d a%0d a%0d wd%h want a0 a3 a3(wr 01)",
                la[base % 64], la[(base + 1) % 64], la[(base + 2) % 64], ld[(base + 2) % 64]);
        end
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL irq_idle_after got %b want 0", busy_a); end
    endtask

    task automatic test_commands();
        logic [1:0] op  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [7:0] dat [4] = '{8'hA5, 8'h0F, 8'h03, 8'h01};
        logic [2:0] adr [4] = '{3'd0, 3'd4, 3'd5, 3'd2};
        logic [7:0] outx[4] = '{8'hA5, 8'hAF, 8'hAC, 8'hAC};
        for (int k = 0; k < 4; k++) begin
            cmd_valid_a = 1'b1; cmd_op_a = op[k]; cmd_data_a = dat[k];
            n_cmp++; if (cmd_ready_a !== 1'b1) begin n_bad++; $display("FAIL cmd%0d_ready got %b want 1", k, cmd_ready_a); end
            @(negedge clk);
            cmd_valid_a = 1'b0;
            n_cmp++;
            if ({cs_a, wn_a, addr_a, wd_a} !== {1'b1, 1'b0, adr[k], 24'h0, dat[k]}) begin
                n_bad++; $display("FAIL cmd%0d_strobe got cs%b wn%b a%0d d%h want cs1 wn0 a%0d d%h",
                    k, cs_a, wn_a, addr_a, wd_a, adr[k], dat[k]);
            end
            @(negedge clk);
            n_cmp++; if (out_a !== outx[k]) begin n_bad++; $display("FAIL cmd%0d_pio_out got %h want %h", k, out_a, outx[k]); end
            n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL cmd%0d_idle got %b want 0", k, busy_a); end
        end
        n_cmp++; if (mask_a !== 8'h01) begin n_bad++; $display("FAIL cmd_mask got %h want 01", mask_a); end
    endtask

    task automatic test_priority();
        int ev = -1;
        int wr = -1;
        logic [7:0] d = 8'h00;
        pin_a = 8'h02; set_a = 8'h02;
        @(negedge clk);
        set_a = 8'h00;
        cmd_valid_a = 1'b1; cmd_op_a = 2'b00; cmd_data_a = 8'h5A;
        n_cmp++; if (cmd_ready_a !== 1'b0) begin n_bad++; $display("FAIL prio_cmd_ready got %b want 0", cmd_ready_a); end
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (evt_valid_a && ev < 0) begin ev = i; d = evt_data_a; end
            if (cs_a && !wn_a && addr_a == 3'd0 && wr < 0) begin wr = i; cmd_valid_a = 1'b0; end
        end
        cmd_valid_a = 1'b0;
        n_cmp++; if (ev != 6) begin n_bad++; $display("FAIL prio_evt_cycle got %0d want 6", ev); end
        n_cmp++; if (d !== 8'h02) begin n_bad++; $display("FAIL prio_evt_data got %h want 02", d); end
        n_cmp++; if (wr != 8) begin n_bad++; $display("FAIL prio_cmd_cycle got %0d want 8", wr); end
        n_cmp++; if (out_a !== 8'h5A) begin n_bad++; $display("FAIL prio_pio_out got %h want 5a", out_a); end
    endtask

    task automatic test_spurious();
        int sp = -1;
        int nsp = 0;
        int evs = 0;
        int nwr = 0;
        int base = na;
        force_a = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) force_a = 1'b0;
            if (spur_a) begin nsp++; sp = i; end
            if (evt_valid_a) evs++;
        end
        for (int j = base; j < na; j++) if (!lw[j % 64]) nwr++;
        n_cmp++; if (nsp != 1) begin n_bad++; $display("FAIL spur_pulse_count got %0d want 1", nsp); end
        n_cmp++; if (sp != 5) begin n_bad++; $display("FAIL spur_cycle got %0d want 5", sp); end
        n_cmp++; if (evs != 0) begin n_bad++; $display("FAIL spur_event got %0d want 0", evs); end
        n_cmp++; if (nwr != 0) begin n_bad++; $display("FAIL spur_writes got %0d want 0", nwr); end
        n_cmp++; if (na - base != 2) begin n_bad++; $display("FAIL spur_reads got %0d want 2", na - base); end
    endtask

    task automatic test_backpressure();
        int t = 0;
        int bad = 0;
        logic [7:0] d, e;
        evt_ready_a = 1'b0;
        pin_a = 8'h04; set_a = 8'h04;
        @(negedge clk);
        set_a = 8'h00;
        while (!evt_valid_a && t < 12) begin @(negedge clk); t++; end
        n_cmp++; if (evt_valid_a !== 1'b1) begin n_bad++; $display("FAIL bp_evt_seen got %b want 1 (t=%0d)", evt_valid_a, t); end
        d = evt_data_a; e = evt_edges_a;
        n_cmp++; if ({d, e} !== 16'h0404) begin n_bad++; $display("FAIL bp_evt_value got %h/%h want 04/04", d, e); end
        cmd_valid_a = 1'b1; cmd_op_a = 2'b01; cmd_data_a = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (evt_valid_a !== 1'b1 || evt_data_a !== d || evt_edges_a !== e ||
                cmd_ready_a !== 1'b0 || cs_a !== 1'b0) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
        cmd_valid_a = 1'b0; evt_ready_a = 1'b1;
        @(negedge clk);
        n_cmp++; if ({evt_valid_a, busy_a} !== 2'b00) begin n_bad++; $display("FAIL bp_release got %b want 00", {evt_valid_a, busy_a}); end
        n_cmp++; if (out_a !== 8'h5A) begin n_bad++; $display("FAIL bp_no_cmd got %h want 5a", out_a); end
    endtask

    task automatic test_stall();
        int ev = -1;
        int bad = 0;
        int stalls = 0;
        int base = nb;
        logic pw = 1'b0;
        logic [35:0] prev = '0;
        logic [7:0] d = 8'h00, e = 8'h00;
        pin_b = 8'h81; set_b = 8'h01;
        @(negedge clk);
        set_b = 8'h00;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (pw && {addr_b, wn_b, wd_b} !== prev) bad++;
            pw = cs_b && wreq_b;
            if (pw) stalls++;
            prev = {addr_b, wn_b, wd_b};
            if (evt_valid_b && ev < 0) begin ev = i; d = evt_data_b; e = evt_edges_b; end
        end
        n_cmp++; if (ev != 17) begin n_bad++; $display("FAIL stall_evt_cycle got %0d want 17", ev); end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL stall_bus_stable got %0d changes want 0", bad); end
        n_cmp++; if (stalls != 9) begin n_bad++; $display("FAIL stall_cycles got %0d want 9", stalls); end
        n_cmp++; if ({d, e} !== 16'h8101) begin n_bad++; $display("FAIL stall_evt_value got %h/%h want 81/01", d, e); end
        n_cmp++; if (nb - base != 3) begin n_bad++; $display("FAIL stall_xfers got %0d want 3", nb - base); end
        n_cmp++; if (irq_b !== 1'b0) begin n_bad++; $display("FAIL stall_irq_cleared got %b want 0", irq_b); end
    endtask

    task automatic test_reset_mid();
        int ev = -1;
        logic [7:0] e = 8'h00;
        pin_a = 8'h08; set_a = 8'h08;
        @(negedge clk);
        set_a = 8'h00;
        repeat (4) @(negedge clk);
        n_cmp++; if ({busy_a, evt_data_a} !== {1'b1, 8'h08}) begin n_bad++; $display("FAIL rmid_pre got %b/%h want 1/08", busy_a, evt_data_a); end
        rst = 1'b1; #1;
        n_cmp++;
        if ({cs_a, wn_a, addr_a, wd_a, evt_valid_a, evt_data_a, evt_edges_a, spur_a, busy_a, cmd_ready_a}
            !== {1'b0, 1'b1, 3'd0, 32'h0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL rmid_outputs got cs%b wn%b a%0d d%h ev%b ed%h ee%h sp%b bz%b rdy%b want reset values",
                cs_a, wn_a, addr_a, wd_a, evt_valid_a, evt_data_a, evt_edges_a, spur_a, busy_a, cmd_ready_a);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) begin
                n_cmp++;
                if ({cs_a, wn_a, addr_a} !== {1'b1, 1'b1, 3'd0}) begin
                    n_bad++; $display("FAIL rmid_restart got cs%b wn%b a%0d want cs1 wn1 a0", cs_a, wn_a, addr_a);
                end
            end
            if (evt_valid_a && ev < 0) begin ev = i; e = evt_edges_a; end
        end
        n_cmp++; if (ev != 6) begin n_bad++; $display("FAIL rmid_evt_cycle got %0d want 6", ev); end
        n_cmp++; if (e !== 8'h08) begin n_bad++; $display("FAIL rmid_evt_edges got %h want 08", e); end
    endtask

    initial begin
        test_reset();
        test_irq_service();
        test_commands();
        test_priority();
        test_spurious();
        test_backpressure();
        test_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
